sad_search_ctrl: RTL and testbench

- Sequences the SAD datapath (32-pixel ori/can rows, WIDTH-bit pixels) over a list of candidate blocks.
- For each candidate it presents an index for the candidate-row fetch and runs one init/done/ack transaction on the SAD core.
- Tracks the minimum SAD and the index where it occurred, then reports both to the host through a done/ack handshake.
- Sits between the host/motion-search logic and top_level.

---
 rtl/sad_pkg.sv | 19 +
 rtl/sad_min_tracker.sv | 48 ++++
 rtl/sad_search_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and defaults for the SAD candidate search controller.
package sad_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SAD_W = DEF_WIDTH + 5;
  localparam int unsigned DEF_IDX_W = 6;

  // Starting value of the running minimum, so any real SAD replaces it.
  localparam logic [DEF_SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sad_min_tracker.sv
// Captures each candidate SAD and keeps the strict running minimum and its index.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int unsigned SAD_W = DEF_SAD_W,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic             update,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic [SAD_W-1:0] next_best_c
);

  logic [SAD_W-1:0] cap_q;
  logic             lt_c;

  // Strict less-than so ties keep the earliest index.
  assign lt_c        = cap_q < best_sad;
  assign next_best_c = lt_c ? cap_q : best_sad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q <= sad_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (clear) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (update && lt_c) begin
      best_sad <= cap_q;
      best_idx <= cand_idx;
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Walks a candidate list through the SAD core and reports the minimum SAD and its index.
// Optional threshold early exit: define SAD_EARLY_EXIT_EN.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SAD_W = WIDTH + 5,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_cands,
  input  logic             host_ack,
  output logic [IDX_W-1:0] cand_idx,
  output logic             sad_init,
  output logic             sad_ack,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_value,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
`ifdef SAD_EARLY_EXIT_EN
  ,
  input  logic [SAD_W-1:0] thresh,
  output logic             early
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] cand_d;
  logic             init_d, ack_d, busy_d, done_d;
  logic             clear_c, capture_c, update_c;
  logic             last_c, early_hit_c;
  logic [SAD_W-1:0] next_best;

  assign last_c = cand_idx == (num_q - IDX_W'(1));

  sad_min_tracker #(
    .SAD_W (SAD_W),
    .IDX_W (IDX_W)
  ) u_min (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_c),
    .capture     (capture_c),
    .update      (update_c),
    .sad_value   (sad_value),
    .cand_idx    (cand_idx),
    .best_sad    (best_sad),
    .best_idx    (best_idx),
    .next_best_c (next_best)
  );

`ifdef SAD_EARLY_EXIT_EN
  logic [SAD_W-1:0] thresh_q;

  // Threshold check uses the minimum as it will be after this ACK's update.
  assign early_hit_c = next_best <= thresh_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thresh_q <= '0;
      early    <= 1'b0;
    end else if (state_q == IDLE && start) begin
      thresh_q <= thresh;
      early    <= 1'b0;
    end else if (state_q == ACK && early_hit_c) begin
      early    <= 1'b1;
    end
  end
`else
  logic unused_next_best;

  assign early_hit_c      = 1'b0;
  assign unused_next_best = ^next_best;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      cand_idx <= '0;
      sad_init <= 1'b0;
      sad_ack  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      cand_idx <= cand_d;
      sad_init <= init_d;
      sad_ack  <= ack_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    cand_d    = cand_idx;
    init_d    = 1'b0;
    ack_d     = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    clear_c   = 1'b0;
    capture_c = 1'b0;
    update_c  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          clear_c = 1'b1;
          num_d   = num_cands;
          cand_d  = '0;
          if (num_cands != '0) begin
            state_d = LOAD;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = RUN;
        init_d  = 1'b1;
      end
      RUN: begin
        if (sad_done) begin
          capture_c = 1'b1;
          state_d   = ACK;
          ack_d     = 1'b1;
        end else begin
          init_d = 1'b1;
        end
      end
      ACK: begin
        update_c = 1'b1;
        if (last_c || early_hit_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cand_d  = cand_idx + IDX_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        if (host_ack) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomized self-checking bench for sad_search_ctrl with a behavioural core and search model.
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int unsigned WIDTH = DEF_WIDTH;
  localparam int unsigned SAD_W = WIDTH + 5;
  localparam int unsigned IDX_W = DEF_IDX_W;
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic             clk, rst, start, host_ack;
  logic [IDX_W-1:0] num_cands, cand_idx, best_idx;
  logic             sad_init, sad_ack, sad_done, busy, done;
  logic [SAD_W-1:0] sad_value, best_sad;
`ifdef SAD_EARLY_EXIT_EN
  logic [SAD_W-1:0] thresh;
  logic             early;
`endif

  int checks = 0;
  int failures = 0;
  int core_lat = 3;
  int core_cnt;
  logic [SAD_W-1:0] vals [64];

  sad_search_ctrl #(.WIDTH(WIDTH), .SAD_W(SAD_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_cands (num_cands),
    .host_ack  (host_ack),
    .cand_idx  (cand_idx),
    .sad_init  (sad_init),
    .sad_ack   (sad_ack),
    .sad_done  (sad_done),
    .sad_value (sad_value),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx)
`ifdef SAD_EARLY_EXIT_EN
    ,
    .thresh    (thresh),
    .early     (early)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: RUN lasts core_lat cycles; done drops once ack is seen.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_cnt  <= 0;
      sad_done  <= 1'b0;
      sad_value <= '0;
    end else if (sad_ack) begin
      core_cnt <= 0;
      sad_done <= 1'b0;
    end else if (sad_init && !sad_done) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_lat - 1) begin
        sad_done  <= 1'b1;
        sad_value <= vals[cand_idx];
      end
    end
  end

  task automatic do_search(input int n, input int lat, input logic [SAD_W-1:0] th,
                           input bit inject, input int hold, input string name);
    logic [SAD_W-1:0] e_best;
    int e_idx, e_eval, edges, init_cycles, prev_ack;
    bit e_early, seq_ok, stable_ok, timed_out;
    int ack_q[$];
    e_best = '1; e_idx = 0; e_eval = 0; e_early = 1'b0;
    for (int i = 0; i < n; i++) begin
      e_eval++;
      if (vals[i] < e_best) begin e_best = vals[i]; e_idx = i; end
      if (EARLY_EN && e_best <= th) begin e_early = 1'b1; break; end
    end
    core_lat = lat;
    @(negedge clk);
    start = 1'b1; num_cands = IDX_W'(n);
`ifdef SAD_EARLY_EXIT_EN
    thresh = th;
`endif
    @(posedge clk);
    edges = 1; init_cycles = 0; prev_ack = 0; timed_out = 1'b1;
    while (edges < 5000) begin
      @(negedge clk);
      start = 1'b0; host_ack = 1'b0; num_cands = IDX_W'($urandom);
`ifdef SAD_EARLY_EXIT_EN
      thresh = SAD_W'($urandom);
`endif
      if (done) begin timed_out = 1'b0; break; end
      if (sad_init) init_cycles++;
      if (sad_ack) begin
        ack_q.push_back(int'(cand_idx));
        checks++;
        if (sad_init !== 1'b0 || prev_ack != 0) begin
          failures++;
          $display("FAIL %s ack_pulse: init=%b prev_ack=%0d required init=0 single-cycle ack", name, sad_init, prev_ack);
        end
      end
      prev_ack = int'(sad_ack);
      if (inject) begin
        start    = sad_init;
        host_ack = busy & ~sad_init & ~sad_ack;
      end
      @(posedge clk);
      edges++;
    end
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s timeout: done not seen after %0d cycles", name, edges);
      rst = 1'b0; #3; rst = 1'b1;
      return;
    end
    checks++;
    if (edges != e_eval * (2 + lat) + 1) begin
      failures++; $display("FAIL %s latency: got %0d required %0d", name, edges, e_eval * (2 + lat) + 1);
    end
    checks++;
    if (best_sad !== e_best || best_idx !== IDX_W'(e_idx)) begin
      failures++;
      $display("FAIL %s best: got sad=%0d idx=%0d required sad=%0d idx=%0d", name, best_sad, best_idx, e_best, e_idx);
    end
    seq_ok = (ack_q.size() == e_eval);
    foreach (ack_q[i]) if (ack_q[i] != i) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      failures++; $display("FAIL %s ack_seq: got %0d acks required %0d in order", name, ack_q.size(), e_eval);
    end
    checks++;
    if (init_cycles != e_eval * lat || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s init_busy: init_cycles=%0d busy=%b required %0d busy=1", name, init_cycles, busy, e_eval * lat);
    end
`ifdef SAD_EARLY_EXIT_EN
    checks++;
    if (early !== e_early) begin
      failures++; $display("FAIL %s early: got %b required %b", name, early, e_early);
    end
`else
    if (e_early) $display("note: unexpected early model flag");
`endif
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (done !== 1'b1 || best_sad !== e_best || best_idx !== IDX_W'(e_idx)) stable_ok = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!stable_ok) begin
        failures++; $display("FAIL %s hold: done/best changed without host_ack, done=%b", name, done);
      end
    end
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || best_sad !== e_best || best_idx !== IDX_W'(e_idx)) begin
      failures++;
      $display("FAIL %s release: done=%b busy=%b sad=%0d required done=0 busy=0 sad=%0d", name, done, busy, best_sad, e_best);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sad_init !== 1'b0 || sad_ack !== 1'b0 ||
        cand_idx !== '0 || best_sad !== SAD_MAX || best_idx !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b init=%b ack=%b idx=%0d sad=%0d bidx=%0d required zeros and sad=%0d",
               busy, done, sad_init, sad_ack, cand_idx, best_sad, best_idx, SAD_MAX);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    vals[0] = 500; vals[1] = 120; vals[2] = 300; vals[3] = 90;
    do_search(4, 3, '0, 1'b0, 0, "basic");
  endtask

  task automatic test_tie();
    vals[0] = 40; vals[1] = 40; vals[2] = 55;
    do_search(3, 3, '0, 1'b0, 0, "tie");
  endtask

  task automatic test_zero();
    do_search(0, 3, '0, 1'b0, 0, "zero_cands");
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 5; i++) vals[i] = SAD_W'($urandom_range(1, 8000));
    do_search(5, 4, '0, 1'b1, 20, "ignore_hold");
  endtask

  task automatic test_early();
    vals[0] = 300; vals[1] = 80; vals[2] = 10; vals[3] = 5;
    do_search(4, 3, SAD_W'(100), 1'b0, 0, "early_exit");
  endtask

  task automatic test_reset_mid();
    int guard;
    for (int i = 0; i < 4; i++) vals[i] = SAD_W'($urandom_range(1, 8000));
    core_lat = 3;
    @(negedge clk);
    start = 1'b1; num_cands = IDX_W'(4);
`ifdef SAD_EARLY_EXIT_EN
    thresh = '0;
`endif
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(cand_idx == IDX_W'(2) && sad_init) && guard < 200) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++; $display("FAIL reset_mid wait: candidate 2 RUN not reached in %0d cycles", guard);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sad_init !== 1'b0 || sad_ack !== 1'b0 || best_sad !== SAD_MAX || cand_idx !== '0) begin
      failures++;
      $display("FAIL reset_mid async: busy=%b init=%b ack=%b sad=%0d idx=%0d required 0 0 0 %0d 0",
               busy, sad_init, sad_ack, best_sad, cand_idx, SAD_MAX);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sad_init !== 1'b0 || done !== 1'b0 || best_sad !== SAD_MAX) begin
      failures++;
      $display("FAIL reset_mid next: busy=%b init=%b done=%b sad=%0d required 0 0 0 %0d", busy, sad_init, done, best_sad, SAD_MAX);
    end
    rst = 1'b1;
    do_search(4, 3, '0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [SAD_W-1:0] th;
      n  = $urandom_range(1, 20);
      th = SAD_W'($urandom_range(0, 600));
      for (int i = 0; i < n; i++) vals[i] = SAD_W'($urandom);
      do_search(n, $urandom_range(2, 5), th, t[0], 0, "random");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; host_ack = 1'b0; num_cands = '0;
`ifdef SAD_EARLY_EXIT_EN
    thresh = '0;
`endif
    foreach (vals[i]) vals[i] = '1;
    test_reset();
    test_basic();
    test_tie();
    test_zero();
    test_ignore();
    test_early();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
